hci_core_mem_arbiter: RTL and testbench

Round-robin arbiter sharing one HCI memory-side port among N_REQ HCI core-side requesters. Sits between accelerator/streamer masters and a single TCDM bank or memory port. It picks one requester per cycle, forwards the request with the requester index as ID, and routes the fixed-latency (1-cycle) response back to the issuing requester. Target implementation is roughly 150–250 lines of RTL.

---
 rtl/hci_core_mem_arbiter_pkg.sv | 10 +
 rtl/hci_core_mem_arbiter_rr_sel.sv | 41 ++++
 rtl/hci_core_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_hci_core_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_core_mem_arbiter_pkg.sv
// Shared definitions for the HCI core-to-memory round-robin arbiter.
// Memory responses arrive exactly one cycle after the request handshake.
package hci_core_mem_arbiter_pkg;

  // Requester index width: $clog2(n) with a floor of one bit.
  function automatic int unsigned hci_arb_idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hci_core_mem_arbiter_rr_sel.sv
// Combinational round-robin selector: first eligible index at or after rr_ptr_i,
// scanning upward and wrapping modulo N_REQ.
module hci_core_mem_arbiter_rr_sel
  import hci_core_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]                    elig_i,
  input  logic [hci_arb_idx_w(N_REQ)-1:0]     rr_ptr_i,
  output logic [hci_arb_idx_w(N_REQ)-1:0]     winner_o,
  output logic                                any_valid_o
);

  localparam int unsigned IdxW = hci_arb_idx_w(N_REQ);
  localparam int unsigned SumW = IdxW + 1;

  logic [N_REQ-1:0] rot;
  logic [IdxW-1:0]  off;
  logic             found;
  logic [SumW-1:0]  sum;

  always_comb begin
    // Doubling the vector lets a plain shift implement the wrap-around.
    rot   = N_REQ'({elig_i, elig_i} >> rr_ptr_i);
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!found && rot[k]) begin
        off   = IdxW'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, rr_ptr_i} + {1'b0, off};
    if (sum >= SumW'(N_REQ)) begin
      sum = sum - SumW'(N_REQ);
    end
    winner_o    = sum[IdxW-1:0];
    any_valid_o = |elig_i;
  end

endmodule

// File: rtl/hci_core_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency HCI memory port among N_REQ
// core-side requesters; the response is routed back using the registered winner.
module hci_core_mem_arbiter
  import hci_core_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned BW    = 8,
  parameter int unsigned IW    = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  // Core-side requesters
  input  logic [N_REQ-1:0]                core_req_i,
  output logic [N_REQ-1:0]                core_gnt_o,
  input  logic [N_REQ-1:0][AW-1:0]        core_add_i,
  input  logic [N_REQ-1:0]                core_wen_i,
  input  logic [N_REQ-1:0][DW-1:0]        core_data_i,
  input  logic [N_REQ-1:0][DW/BW-1:0]     core_be_i,
  input  logic [N_REQ-1:0]                core_lrdy_i,
  output logic [N_REQ-1:0][DW-1:0]        core_r_data_o,
  output logic [N_REQ-1:0]                core_r_valid_o,
  output logic [N_REQ-1:0]                core_r_opc_o,
  // Shared memory port
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic [AW-1:0]                   mem_add_o,
  output logic                            mem_wen_o,
  output logic [DW-1:0]                   mem_data_o,
  output logic [DW/BW-1:0]                mem_be_o,
  output logic [IW-1:0]                   mem_id_o,
  input  logic [DW-1:0]                   mem_r_data_i,
  input  logic [IW-1:0]                   mem_r_id_i
);

  localparam int unsigned IdxW = hci_arb_idx_w(N_REQ);

  if (N_REQ < 2) begin : g_nreq_chk
    $error("hci_core_mem_arbiter: N_REQ must be at least 2");
  end
  if (IW < $clog2(N_REQ)) begin : g_iw_chk
    $error("hci_core_mem_arbiter: IW too narrow for N_REQ requester indices");
  end

  logic [N_REQ-1:0] elig;
  logic [IdxW-1:0]  winner;
  logic             any_elig;
  logic             handshake;

  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             resp_vld_q, resp_vld_d;
  logic [IdxW-1:0]  resp_idx_q, resp_idx_d;
  logic             resp_opc_q, resp_opc_d;

  // A load is only eligible when its issuer can take the response.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      elig[i] = core_req_i[i] & (~core_wen_i[i] | core_lrdy_i[i]);
    end
  end

  hci_core_mem_arbiter_rr_sel #(
    .N_REQ (N_REQ)
  ) u_rr_sel (
    .elig_i      (elig),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_elig)
  );

  assign handshake = any_elig & mem_gnt_i;

  always_comb begin
    mem_req_o  = any_elig;
    mem_add_o  = core_add_i[winner];
    mem_wen_o  = core_wen_i[winner];
    mem_data_o = core_data_i[winner];
    mem_be_o   = core_be_i[winner];
    mem_id_o   = IW'(winner);
    core_gnt_o = '0;
    if (handshake) begin
      core_gnt_o[winner] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    resp_vld_d = 1'b0;
    resp_idx_d = resp_idx_q;
    resp_opc_d = resp_opc_q;
    if (handshake) begin
      rr_ptr_d   = (winner == IdxW'(N_REQ - 1)) ? '0 : winner + IdxW'(1);
      resp_vld_d = 1'b1;
      resp_idx_d = winner;
      resp_opc_d = 1'b0;
    end
    if (clear_i) begin
      rr_ptr_d   = '0;
      resp_vld_d = 1'b0;
      resp_idx_d = '0;
      resp_opc_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      resp_vld_q <= 1'b0;
      resp_idx_q <= '0;
      resp_opc_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      resp_vld_q <= resp_vld_d;
      resp_idx_q <= resp_idx_d;
      resp_opc_q <= resp_opc_d;
    end
  end

  // Read data is broadcast; only r_valid identifies the owner.
  always_comb begin
    core_r_valid_o = '0;
    if (resp_vld_q) begin
      core_r_valid_o[resp_idx_q] = 1'b1;
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      core_r_data_o[i] = mem_r_data_i;
    end
    core_r_opc_o = {N_REQ{resp_opc_q}};
  end

`ifndef SYNTHESIS
  a_resp_id: assert property (@(posedge clk_i) disable iff (rst_i)
    resp_vld_q |-> (mem_r_id_i == IW'(resp_idx_q)));
`endif

endmodule

// File: tb/tb_hci_core_mem_arbiter.sv
// Self-checking bench for hci_core_mem_arbiter: directed scenarios plus
// randomized traffic against a cycle-level behavioural reference model.
module tb_hci_core_mem_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned BW  = 8;
  localparam int unsigned IW  = 8;
  localparam int unsigned BEW = DW / BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst, clear;
  logic [N-1:0]            req, gnt, wen, lrdy, r_valid, r_opc;
  logic [N-1:0][AW-1:0]    add;
  logic [N-1:0][DW-1:0]    data, r_data;
  logic [N-1:0][BEW-1:0]   be;
  logic                    mem_req, mem_gnt, mem_wen;
  logic [AW-1:0]           mem_add;
  logic [DW-1:0]           mem_data, mem_r_data;
  logic [BEW-1:0]          mem_be;
  logic [IW-1:0]           mem_id, mem_r_id;

  hci_core_mem_arbiter #(
    .N_REQ (N),
    .DW    (DW),
    .AW    (AW),
    .BW    (BW),
    .IW    (IW)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .core_req_i     (req),
    .core_gnt_o     (gnt),
    .core_add_i     (add),
    .core_wen_i     (wen),
    .core_data_i    (data),
    .core_be_i      (be),
    .core_lrdy_i    (lrdy),
    .core_r_data_o  (r_data),
    .core_r_valid_o (r_valid),
    .core_r_opc_o   (r_opc),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_add_o      (mem_add),
    .mem_wen_o      (mem_wen),
    .mem_data_o     (mem_data),
    .mem_be_o       (mem_be),
    .mem_id_o       (mem_id),
    .mem_r_data_i   (mem_r_data),
    .mem_r_id_i     (mem_r_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: next requester to favour and the pending response.
  int m_ptr;
  int m_idx;
  bit m_vld;

  logic [N-1:0]    obs_gnt, obs_rvalid;
  logic            obs_req;
  logic [IW-1:0]   obs_id;
  logic [AW-1:0]   obs_add;
  logic [DW-1:0]   obs_rdata2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_elig(input int i);
    return req[i] && (!wen[i] || lrdy[i]);
  endfunction

  // First eligible requester at or after m_ptr, wrapping; -1 when none.
  function automatic int model_winner();
    for (int k = 0; k < int'(N); k++) begin
      if (is_elig((m_ptr + k) % N)) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_vld = 1'b0;
    m_idx = 0;
  endtask

  task automatic clear_inputs();
    req     = '0;
    wen     = '0;
    lrdy    = '0;
    mem_gnt = 1'b0;
    clear   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      add[i]  = AW'($urandom);
      data[i] = DW'($urandom);
      be[i]   = BEW'($urandom);
    end
  endtask

  // Called 1 time unit after a rising edge; checks mid-cycle, returns after the next edge.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_gnt, exp_rv;
    #4;
    w       = model_winner();
    exp_gnt = '0;
    if (w >= 0 && mem_gnt) exp_gnt[w] = 1'b1;
    exp_rv = '0;
    if (m_vld) exp_rv[m_idx] = 1'b1;
    obs_gnt    = gnt;
    obs_rvalid = r_valid;
    obs_req    = mem_req;
    obs_id     = mem_id;
    obs_add    = mem_add;
    obs_rdata2 = r_data[2];
    check_eq("mem_req", 64'(mem_req), 64'(w >= 0));
    if (w >= 0) begin
      check_eq("mem_id",   64'(mem_id),   64'(w));
      check_eq("mem_add",  64'(mem_add),  64'(add[w]));
      check_eq("mem_wen",  64'(mem_wen),  64'(wen[w]));
      check_eq("mem_data", 64'(mem_data), 64'(data[w]));
      check_eq("mem_be",   64'(mem_be),   64'(be[w]));
    end
    check_eq("core_gnt",  64'(gnt),     64'(exp_gnt));
    check_eq("r_valid",   64'(r_valid), 64'(exp_rv));
    check_eq("r_opc",     64'(r_opc),   64'(0));
    for (int i = 0; i < int'(N); i++) begin
      check_eq("r_data_bcast", 64'(r_data[i]), 64'(mem_r_data));
    end
    @(posedge clk);
    if (rst || clear) begin
      model_reset();
    end else if (w >= 0 && mem_gnt) begin
      m_ptr = (w + 1) % N;
      m_vld = 1'b1;
      m_idx = w;
    end else begin
      m_vld = 1'b0;
    end
    #1;
    mem_r_id   = IW'(m_idx);
    mem_r_data = DW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    clear_inputs();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    mem_r_id   = '0;
    mem_r_data = '0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    check_eq("reset_gnt",    64'(obs_gnt),    64'(0));
    check_eq("reset_rvalid", 64'(obs_rvalid), 64'(0));
    check_eq("reset_memreq", 64'(obs_req),    64'(0));

    // Single load from requester 2.
    req[2] = 1'b1; wen[2] = 1'b1; lrdy[2] = 1'b1; add[2] = 32'h100; mem_gnt = 1'b1;
    cycle();
    check_eq("t1_id",  64'(obs_id),  64'(2));
    check_eq("t1_add", 64'(obs_add), 64'h100);
    check_eq("t1_gnt", 64'(obs_gnt), 64'b0100);
    req = '0;
    mem_r_data = 32'hDEADBEEF;
    cycle();
    check_eq("t1_rvalid", 64'(obs_rvalid), 64'b0100);
    check_eq("t1_rdata",  64'(obs_rdata2), 64'hDEADBEEF);

    // All requesters continuously: grants rotate, responses follow one cycle later.
    do_reset();
    req = '1; wen = '0; mem_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_eq("t2_gnt_seq", 64'(obs_gnt), 64'(1 << (k % 4)));
      if (k > 0) check_eq("t2_rv_seq", 64'(obs_rvalid), 64'(1 << ((k - 1) % 4)));
    end

    // Stall with mem_gnt low, then release.
    do_reset();
    req[1] = 1'b1; req[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("t3_stall_gnt", 64'(obs_gnt), 64'(0));
      check_eq("t3_stall_id",  64'(obs_id),  64'(1));
    end
    mem_gnt = 1'b1;
    cycle();
    check_eq("t3_first",  64'(obs_gnt), 64'b0010);
    cycle();
    check_eq("t3_second", 64'(obs_gnt), 64'b1000);

    // Load without lrdy is skipped; becomes eligible once lrdy rises.
    do_reset();
    req[0] = 1'b1; wen[0] = 1'b1; lrdy[0] = 1'b0;
    req[1] = 1'b1; wen[1] = 1'b0;
    mem_gnt = 1'b1;
    cycle();
    check_eq("t4_store_only", 64'(obs_gnt), 64'b0010);
    lrdy[0] = 1'b1;
    cycle();
    check_eq("t4_load_next", 64'(obs_gnt), 64'b0001);

    // Back-to-back store from 0 then load from 3.
    do_reset();
    req[0] = 1'b1; wen[0] = 1'b0; mem_gnt = 1'b1;
    cycle();
    req = '0; req[3] = 1'b1; wen[3] = 1'b1; lrdy[3] = 1'b1;
    mem_r_data = 32'h1234_5678;
    cycle();
    check_eq("t5_rv0", 64'(obs_rvalid), 64'b0001);
    check_eq("t5_g3",  64'(obs_gnt),    64'b1000);
    req = '0;
    mem_r_data = 32'hCAFE_F00D;
    cycle();
    check_eq("t5_rv3", 64'(obs_rvalid), 64'b1000);
    cycle();
    check_eq("t5_idle", 64'(obs_rvalid), 64'(0));

    // Reset right after a handshake drops the response and rewinds the pointer.
    do_reset();
    req[2] = 1'b1; wen[2] = 1'b1; lrdy[2] = 1'b1; mem_gnt = 1'b1;
    cycle();
    rst = 1'b1;
    model_reset();
    req = '0;
    cycle();
    check_eq("t6_rv_dropped", 64'(obs_rvalid), 64'(0));
    cycle();
    rst = 1'b0;
    req = '1; wen = '0; mem_gnt = 1'b1;
    cycle();
    check_eq("t6_first_after", 64'(obs_gnt), 64'b0001);

    // Randomized traffic including occasional soft clears.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        req[i]  = 1'($urandom_range(0, 1));
        wen[i]  = 1'($urandom_range(0, 1));
        lrdy[i] = ($urandom_range(0, 3) != 0);
        add[i]  = AW'($urandom);
        data[i] = DW'($urandom);
        be[i]   = BEW'($urandom);
      end
      mem_gnt = ($urandom_range(0, 3) != 0);
      clear   = ($urandom_range(0, 31) == 0);
      cycle();
    end
    clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
